// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//   One pipeline stage with a two-entry skid buffer. It carries {PC, instr,
//   NCH payload channels}. in_ready comes from registered state only, so there
//   is no combinational path from out_ready back to in_ready. With the skid
//   empty and both sides handshaking every cycle, the stage sustains one entry
//   per cycle.
//
// Ports
//   Clk, Rst       rising-edge clock; asynchronous active-low reset
//   Flush          synchronous kill: inserts a bubble and discards any input
//   in_valid/in_ready, PC_in, instr_in, Din    upstream handshake and entry
//   out_valid/out_ready, PC, instr, Dout       downstream handshake and entry
//   stall_cnt      saturating count of cycles with out_valid=1, out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int unsigned DW       = 32,
    parameter int unsigned NCH      = 3,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNTW     = 16
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                Flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         PC_in,
    input  logic [31:0]         instr_in,
    input  logic [NCH*DW-1:0]   Din,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [31:0]         PC,
    output logic [31:0]         instr,
    output logic [NCH*DW-1:0]   Dout,
    output logic [CNTW-1:0]     stall_cnt
);

    typedef struct packed {
        logic [31:0]       pc;
        logic [31:0]       instr;
        logic [NCH*DW-1:0] data;
    } entry_t;

    entry_t main_q, skid_q, in_ent;
    logic   main_v, skid_v, rst_hold;
    logic   in_xfer, out_xfer, drain;

    assign in_ent   = '{pc: PC_in, instr: instr_in, data: Din};
    assign in_ready = ~skid_v & ~rst_hold;
    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = main_v & out_ready;
    // Main can take a new entry this edge: it is either empty or being consumed.
    assign drain    = out_xfer | ~main_v;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            main_q.pc    <= RESET_PC;
            main_q.instr <= '0;
            main_q.data  <= '0;
            skid_q       <= '0;
            main_v       <= 1'b0;
            skid_v       <= 1'b0;
            rst_hold     <= 1'b1;
            stall_cnt    <= '0;
        end else begin
            rst_hold <= 1'b0;

            // Counts back-pressure regardless of Flush.
            if (main_v && !out_ready && stall_cnt != {CNTW{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;

            if (Flush) begin
                // Bubble: PC tracks the incoming PC when one is offered, so
                // the killed slot still carries a meaningful PC downstream.
                main_v       <= 1'b0;
                skid_v       <= 1'b0;
                main_q.instr <= '0;
                main_q.data  <= '0;
                if (in_valid)
                    main_q.pc <= PC_in;
            end else if (drain) begin
                // in_ready is low whenever skid is valid, so a skid refill
                // and a new input never compete for main.
                if (skid_v) begin
                    main_q <= skid_q;
                    main_v <= 1'b1;
                    skid_v <= 1'b0;
                end else if (in_xfer) begin
                    main_q <= in_ent;
                    main_v <= 1'b1;
                end else begin
                    main_v <= 1'b0;
                end
            end else if (in_xfer) begin
                skid_q <= in_ent;
                skid_v <= 1'b1;
            end
        end
    end

    assign out_valid = main_v;
    assign PC        = main_q.pc;
    assign instr     = main_q.instr;
    assign Dout      = main_q.data;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Scoreboard bench. The reference model treats the stage as a FIFO of
//   depth 2 with bubble-on-flush semantics. The visible output is the head
//   entry, or the last shown entry when the FIFO is empty. Checks run half a
//   cycle after the edge and also just after an asynchronous reset.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

    localparam int unsigned DW       = 8;
    localparam int unsigned NCH      = 3;
    localparam int unsigned PW       = NCH * DW;
    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam int unsigned CNTW     = 4;

    logic            Clk = 1'b0;
    logic            Rst = 1'b0;
    logic            Flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     PC_in = '0;
    logic [31:0]     instr_in = '0;
    logic [PW-1:0]   Din = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [31:0]     PC;
    logic [31:0]     instr;
    logic [PW-1:0]   Dout;
    logic [CNTW-1:0] stall_cnt;

    pipe_stage_skid #(.DW(DW), .NCH(NCH), .RESET_PC(RESET_PC), .CNTW(CNTW)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .PC_in(PC_in), .instr_in(instr_in), .Din(Din),
        .out_valid(out_valid), .out_ready(out_ready),
        .PC(PC), .instr(instr), .Dout(Dout), .stall_cnt(stall_cnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0]   pc;
        logic [31:0]   ins;
        logic [PW-1:0] d;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    bit          m_hold = 1'b1;
    ent_t        m_disp = '{pc: RESET_PC, ins: 32'h0, d: '0};
    int unsigned m_cnt  = 0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: updates on the same edges as the DUT, reading only TB-driven inputs.
    initial begin : model
        bit acc, ov;
        forever begin
            @(posedge Clk or negedge Rst);
            if (!Rst) begin
                q.delete();
                m_hold = 1'b1;
                m_disp = '{pc: RESET_PC, ins: 32'h0, d: '0};
                m_cnt  = 0;
            end else begin
                ov  = (q.size() > 0);
                acc = in_valid && (q.size() < 2) && !m_hold;
                if (ov && !out_ready && m_cnt < (2**CNTW - 1))
                    m_cnt++;
                m_hold = 1'b0;
                if (Flush) begin
                    q.delete();
                    if (in_valid) m_disp.pc = PC_in;
                    m_disp.ins = '0;
                    m_disp.d   = '0;
                end else begin
                    if (ov && out_ready) void'(q.pop_front());
                    if (acc) q.push_back('{pc: PC_in, ins: instr_in, d: Din});
                    if (q.size() > 0) m_disp = q[0];
                end
            end
        end
    end

    // Monitor: compares DUT outputs against the model away from the clock edge.
    initial begin : monitor
        forever begin
            @(negedge Clk or negedge Rst);
            #1;
            chk("in_ready",  64'(in_ready),  64'((q.size() < 2) && !m_hold));
            chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("PC",        64'(PC),        64'(m_disp.pc));
            chk("instr",     64'(instr),     64'(m_disp.ins));
            chk("Dout",      64'(Dout),      64'(m_disp.d));
            chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
        end
    end

    // Driver: every task starts and ends 1 time unit after a rising edge.
    task automatic cyc(input bit iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic [PW-1:0] d, input bit ordy, input bit fl);
        in_valid  = iv;
        PC_in     = pc;
        instr_in  = ins;
        Din       = d;
        out_ready = ordy;
        Flush     = fl;
        @(posedge Clk);
        #1;
    endtask

    task automatic mid_reset();
        #2 Rst = 1'b0;
        in_valid = 1'b0;
        Flush    = 1'b0;
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1 Rst = 1'b1;
    endtask

    initial begin : driver
        @(posedge Clk);
        #1;
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        // First cycle after release: in_ready must still be low.
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        // Single entry, one-cycle latency
        cyc(1'b1, 32'h100, 32'h2002_0001, 24'hA1B2C3, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        // Back-to-back stream of 8 entries
        for (int i = 0; i < 8; i++)
            cyc(1'b1, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 24'(i * 7 + 1), 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        // Skid fill: A held in main, B lands in skid, then both drain in order
        cyc(1'b1, 32'h300, 32'hAAAA_0001, 24'h0000AA, 1'b0, 1'b0);
        cyc(1'b1, 32'h304, 32'hBBBB_0002, 24'h0000BB, 1'b0, 1'b0);
        cyc(1'b1, 32'h308, 32'hCCCC_0003, 24'h0000CC, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        // Stall counter saturation with data held
        cyc(1'b1, 32'h500, 32'h5555_0005, 24'h555555, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++)
            cyc(1'b0, 32'h0, 32'h0, '0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        // Flush with main and skid valid: bubble carries PC_in
        cyc(1'b1, 32'h40, 32'h4040_0040, 24'h404040, 1'b0, 1'b0);
        cyc(1'b1, 32'h48, 32'h4848_0048, 24'h484848, 1'b0, 1'b0);
        cyc(1'b1, 32'h44, 32'h4444_0044, 24'h444444, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        // Flush with no input: PC holds
        cyc(1'b1, 32'h60, 32'h6060_0060, 24'h606060, 1'b1, 1'b0);
        cyc(1'b0, 32'h64, 32'h0, '0, 1'b0, 1'b1);

        // Asynchronous reset between edges with both entries valid
        cyc(1'b1, 32'h70, 32'h7070_0070, 24'h707070, 1'b0, 1'b0);
        cyc(1'b1, 32'h74, 32'h7474_0074, 24'h747474, 1'b0, 1'b0);
        mid_reset();
        cyc(1'b1, 32'h78, 32'h7878_0078, 24'h787878, 1'b1, 1'b0);
        cyc(1'b1, 32'h7C, 32'h7C7C_007C, 24'h7C7C7C, 1'b1, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
            end else begin
                cyc($urandom_range(0, 9) < 7, $urandom(), $urandom(), PW'($urandom()),
                    $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
            end
        end
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 32'h0, '0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 Parameter DW, default 32: width of each payload channel.
REQ-002 Parameter NCH, default 3: number of payload channels, range 1..8.
REQ-003 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-004 Parameter CNTW, default 16: stall-counter width.
REQ-005 Ports are as follows, one per line:
- Clk  in  1  sole clock; all state changes on its rising edge.
- Rst  in  1  reset, asynchronous and active-low: Rst=0 resets immediately, independent of Clk.
- Flush  in  1  synchronous kill; inserts a bubble.
- in_valid  in  1  upstream holds a valid entry.
- in_ready  out  1  stage can accept this cycle.
- PC_in  in  32  upstream PC.
- instr_in  in  32  upstream instruction.
- Din  in  NCH*DW  payload; channel k occupies bits [k*DW +: DW].
- out_valid  out  1  PC/instr/Dout hold a valid entry.
- out_ready  in  1  downstream accepts this cycle.
- PC  out  32  registered PC.
- instr  out  32  registered instruction.
- Dout  out  NCH*DW  registered payload, same packing as Din.
- stall_cnt  out  CNTW  saturating count of back-pressured cycles.

Function
REQ-006 The input transfer is in_valid&in_ready; the output transfer is out_valid&out_ready, both sampled at the rising edge of Clk.
REQ-007 Storage is two entries, each holding {PC, instr, payload}: main (drives the outputs) and skid; each entry has its own valid bit.
REQ-008 in_ready SHALL equal NOT skid_valid AND NOT rst_hold, from registered state only, with no combinational path from out_ready.
REQ-009 Latency from an input transfer to out_valid=1 SHALL be 1 cycle when main is empty or drained in the same cycle.
REQ-010 While out_valid=1 and out_ready=0, PC, instr and Dout SHALL hold their values.
REQ-011 If main is valid, not drained, and an input transfer occurs, the input SHALL be written into skid.
REQ-012 When main drains and skid is valid, skid SHALL move into main in that edge and skid_valid SHALL clear.
REQ-013 When main drains, skid is empty and an input transfer occurs, the input SHALL be written directly into main.
REQ-014 When main drains with no input and skid empty, out_valid SHALL go to 0; the output data need not be cleared.
REQ-015 Entry order SHALL be preserved, with no loss and no duplication.
REQ-016 Flush=1 SHALL clear out_valid and skid_valid, set instr and every Dout channel to 0, and discard any input transfer in that cycle.
REQ-017 On Flush, PC SHALL load PC_in if in_valid=1 and otherwise hold its value; this is bubble semantics.
REQ-018 Flush SHALL have priority over all handshakes; an output transfer that coincides with Flush still counts as consumed downstream.
REQ-019 stall_cnt SHALL increment by 1 each cycle with out_valid=1 and out_ready=0, saturate at all-ones, and be unaffected by Flush.
REQ-020 Simultaneous input and output transfers with skid empty SHALL sustain 1 entry per cycle indefinitely.

Reset
REQ-021 While Rst=0, all outputs SHALL be forced as follows: out_valid=0, skid_valid=0, PC=RESET_PC, instr=0, Dout=0, stall_cnt=0, in_ready=0.
REQ-022 Internal flag rst_hold SHALL be set by reset and cleared on the first Clk edge with Rst=1, so in_ready=1 from the second cycle after release.
REQ-023 Reset asserted mid-operation SHALL discard both entries with no partial transfer; skid contents SHALL also be zeroed.

Verification
REQ-024 Reset release, then in_valid=1, PC_in=0x100, instr_in=0x2002_0001, out_ready=1 -> next edge: out_valid=1, PC=0x100, instr=0x2002_0001.
REQ-025 Stream of 8 entries with out_ready=1 every cycle -> 8 consecutive output transfers, in_ready stays 1, stall_cnt=0.
REQ-026 Main holds entry A, out_ready=0, input B accepted -> in_ready=0 next cycle; after out_ready=1, outputs A then B on consecutive cycles.
REQ-027 Main valid with PC=0x40, skid valid, Flush=1, in_valid=1, PC_in=0x44 -> out_valid=0, PC=0x44, instr=0, Dout=0, in_ready=1.
REQ-028 CNTW=4, out_valid=1 with out_ready=0 held for 20 cycles -> stall_cnt=15 and holds; data unchanged throughout.
REQ-029 Rst driven 0 between clock edges while both entries are valid -> outputs reset immediately; in_ready=0 until the second cycle after release.
